// File: rtl/scroll_pkg.sv
// Shared constants for the scrolling seven-segment message driver:
// character codes, active-low segment patterns and the run/hold state type.
package scroll_pkg;

    localparam logic [2:0] CH_H     = 3'd0;
    localparam logic [2:0] CH_E     = 3'd1;
    localparam logic [2:0] CH_L     = 3'd2;
    localparam logic [2:0] CH_O     = 3'd3;
    localparam logic [2:0] CH_BLANK = 3'd4;

    // Bit 0 is segment a through bit 6 segment g; a 0 lights the segment.
    localparam logic [6:0] SEG_H   = 7'h09;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_L   = 7'h47;
    localparam logic [6:0] SEG_O   = 7'h40;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        S_HOLD,
        S_RUN
    } state_t;

endpackage

// File: rtl/scroll_msg_display_if.sv
// Control inputs and display outputs of the scrolling message driver.
// The board side (master) drives controls; the driver (slave) drives the display.
interface scroll_msg_display_if #(
    parameter int N_DISP  = 6,
    parameter int MSG_LEN = 6
);
    logic                         EN;
    logic                         DIR;
    logic [1:0]                   SPEED;
    logic                         STEP;
    logic [N_DISP*7-1:0]          HEX;
    logic [$clog2(MSG_LEN)-1:0]   POS;

    modport master (
        output EN, DIR, SPEED, STEP,
        input  HEX, POS
    );

    modport slave (
        input  EN, DIR, SPEED, STEP,
        output HEX, POS
    );
endinterface

// File: rtl/hex_char_decode.sv
// Combinational decode of a 3-bit character code to active-low segments.
module hex_char_decode
    import scroll_pkg::*;
(
    input  logic [2:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (code)
            CH_H:    seg = SEG_H;
            CH_E:    seg = SEG_E;
            CH_L:    seg = SEG_L;
            CH_O:    seg = SEG_O;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/scroll_msg_display.sv
// Rotates a fixed message across a bank of seven-segment digits, either
// automatically at a selectable rate or one step at a time while held.
module scroll_msg_display
    import scroll_pkg::*;
#(
    parameter int                     N_DISP   = 6,
    parameter int                     MSG_LEN  = 6,
    parameter logic [MSG_LEN*3-1:0]   MSG      = {CH_O, CH_L, CH_L, CH_E, CH_H, CH_BLANK},
    parameter int                     TICK_DIV = 50_000_000
)(
    input logic                  CLOCK_50,
    input logic                  RESET,
    scroll_msg_display_if.slave  bus
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int POS_W = $clog2(MSG_LEN);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [POS_W-1:0]    pos;
    logic [POS_W-1:0]    pos_next;
    logic                step_q;
    logic                advance;
    logic [31:0]         term;
    logic [N_DISP*7-1:0] frame;
    logic [N_DISP*7-1:0] hex;

    assign term = (32'(TICK_DIV) >> bus.SPEED) - 32'd1;

    // A STEP edge that coincides with EN rising is dropped: the transition wins.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        advance    = 1'b0;
        unique case (state)
            S_HOLD: begin
                if (bus.EN) begin
                    state_next = S_RUN;
                    cnt_next   = '0;
                end else if (bus.STEP && !step_q) begin
                    advance = 1'b1;
                end
            end
            S_RUN: begin
                if (32'(cnt) >= term) begin
                    cnt_next = '0;
                    advance  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
                if (!bus.EN) begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_HOLD;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        pos_next = pos;
        if (advance) begin
            if (!bus.DIR)
                pos_next = (pos == POS_W'(MSG_LEN - 1)) ? '0 : pos + POS_W'(1);
            else
                pos_next = (pos == '0) ? POS_W'(MSG_LEN - 1) : pos - POS_W'(1);
        end
    end

    // Leftmost digit (N_DISP-1) shows MSG[pos]; short messages wrap and repeat.
    for (genvar i = 0; i < N_DISP; i++) begin : g_digit
        localparam int OFFSET = N_DISP - 1 - i;
        logic [31:0] idx;
        logic [2:0]  code;

        assign idx = (32'(pos) + 32'(OFFSET)) % 32'(MSG_LEN);

        always_comb begin
            code = CH_BLANK;
            for (int k = 0; k < MSG_LEN; k++) begin
                if (idx == 32'(k))
                    code = MSG[3*k +: 3];
            end
        end

        hex_char_decode u_dec (
            .code (code),
            .seg  (frame[7*i +: 7])
        );
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state  <= S_HOLD;
            cnt    <= '0;
            pos    <= '0;
            step_q <= 1'b0;
            hex    <= '1;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            pos    <= pos_next;
            step_q <= bus.STEP;
            hex    <= frame;
        end
    end

    assign bus.HEX = hex;
    assign bus.POS = pos;

endmodule

// File: tb/tb_scroll_msg_display.sv
// Bench for scroll_msg_display: a default-message instance and a 4-char
// "HELO" instance share stimulus and are compared to a per-instance model.
module tb_scroll_msg_display;

    localparam int TICK = 16;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b0;
    logic       en       = 1'b0;
    logic       dir      = 1'b0;
    logic [1:0] speed    = 2'd0;
    logic       step     = 1'b0;

    int total = 0;
    int bad   = 0;

    scroll_msg_display_if #(.N_DISP(6), .MSG_LEN(6)) bus_a ();
    scroll_msg_display_if #(.N_DISP(6), .MSG_LEN(4)) bus_b ();

    assign bus_a.EN = en;    assign bus_b.EN = en;
    assign bus_a.DIR = dir;  assign bus_b.DIR = dir;
    assign bus_a.SPEED = speed; assign bus_b.SPEED = speed;
    assign bus_a.STEP = step;   assign bus_b.STEP = step;

    scroll_msg_display #(.N_DISP(6), .MSG_LEN(6), .TICK_DIV(TICK)) dut_a (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus_a)
    );

    scroll_msg_display #(.N_DISP(6), .MSG_LEN(4), .MSG(12'b011_010_001_000),
                         .TICK_DIV(TICK)) dut_b (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus_b)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Model state, index 0 = default message, 1 = "HELO"
    int          m_len [2] = '{6, 4};
    int          msg_a [6] = '{4, 0, 1, 2, 2, 3};
    int          msg_b [4] = '{0, 1, 2, 3};
    int          m_pos [2];
    int          m_cnt [2];
    bit          m_run [2];
    bit          m_prev[2];
    logic [41:0] m_hex [2];

    function automatic int charOf(int d, int k);
        return (d == 0) ? msg_a[k] : msg_b[k];
    endfunction

    function automatic logic [6:0] segOf(int c);
        case (c)
            0:       return 7'h09;
            1:       return 7'h06;
            2:       return 7'h47;
            3:       return 7'h40;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [41:0] frameOf(int d, int pos);
        logic [41:0] f;
        for (int i = 0; i < 6; i++)
            f[7*i +: 7] = segOf(charOf(d, (pos + 5 - i) % m_len[d]));
        return f;
    endfunction

    task automatic resetModel();
        for (int d = 0; d < 2; d++) begin
            m_pos[d] = 0; m_cnt[d] = 0; m_run[d] = 0; m_prev[d] = 0;
            m_hex[d] = '1;
        end
    endtask

    // One clock of behaviour, using the inputs present before the edge.
    task automatic stepModel();
        bit adv;
        for (int d = 0; d < 2; d++) begin
            adv = 0;
            m_hex[d] = frameOf(d, m_pos[d]);
            if (m_run[d]) begin
                if (m_cnt[d] >= (TICK >> speed) - 1) begin
                    adv = 1;
                    m_cnt[d] = 0;
                end else begin
                    m_cnt[d]++;
                end
                if (!en) begin
                    m_run[d] = 0;
                    m_cnt[d] = 0;
                end
            end else if (en) begin
                m_run[d] = 1;
                m_cnt[d] = 0;
            end else if (step && !m_prev[d]) begin
                adv = 1;
            end
            m_prev[d] = step;
            if (adv)
                m_pos[d] = dir ? (m_pos[d] + m_len[d] - 1) % m_len[d]
                               : (m_pos[d] + 1) % m_len[d];
        end
    endtask

    task automatic checkOutput(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("hexA", 64'(bus_a.HEX), 64'(m_hex[0]));
        checkOutput("posA", 64'(bus_a.POS), 64'(m_pos[0]));
        checkOutput("hexB", 64'(bus_b.HEX), 64'(m_hex[1]));
        checkOutput("posB", 64'(bus_b.POS), 64'(m_pos[1]));
    endtask

    // Called one time unit after an edge; leaves time at one unit after the last edge.
    task automatic applyStimulus(bit e, bit d, logic [1:0] s, bit st, int cycles);
        en = e; dir = d; speed = s; step = st;
        for (int c = 0; c < cycles; c++) begin
            stepModel();
            @(posedge CLOCK_50);
            #1;
            checkAll();
        end
    endtask

    task automatic pulseReset();
        RESET = 1'b1;
        resetModel();
        #1;
        checkAll();
        repeat (2) begin
            @(posedge CLOCK_50);
            #1;
            checkAll();
        end
        RESET = 1'b0;
    endtask

    initial begin
        resetModel();
        @(posedge CLOCK_50);
        #1;
        pulseReset();
        checkOutput("hexA_all_dark", 64'(bus_a.HEX), 64'(42'h3FF_FFFF_FFFF));

        applyStimulus(0, 0, 2'd0, 0, 1);
        checkOutput("hexA_first_frame", 64'(bus_a.HEX),
                    64'({7'h7F, 7'h09, 7'h06, 7'h47, 7'h47, 7'h40}));
        checkOutput("hexB_first_frame", 64'(bus_b.HEX),
                    64'({7'h09, 7'h06, 7'h47, 7'h40, 7'h09, 7'h06}));

        applyStimulus(1, 0, 2'd0, 0, 96);
        applyStimulus(1, 1, 2'd0, 0, 20);
        applyStimulus(1, 1, 2'd3, 0, 12);

        // Held stepping, then a long STEP level that must advance once
        applyStimulus(0, 0, 2'd0, 0, 2);
        repeat (3) begin
            applyStimulus(0, 0, 2'd0, 1, 1);
            applyStimulus(0, 0, 2'd0, 0, 2);
        end
        applyStimulus(0, 0, 2'd0, 1, 10);
        applyStimulus(0, 0, 2'd0, 0, 2);

        // Shorten the period while the counter sits at 10
        applyStimulus(1, 0, 2'd0, 0, 11);
        applyStimulus(1, 0, 2'd2, 0, 9);

        // EN rising together with a STEP edge
        applyStimulus(0, 0, 2'd0, 0, 2);
        applyStimulus(1, 0, 2'd0, 1, 2);
        applyStimulus(0, 0, 2'd0, 0, 2);

        for (int r = 0; r < 400; r++) begin
            logic       e;
            logic       d;
            logic [1:0] s;
            e = ($urandom_range(0, 15) == 0) ? ~en : en;
            d = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            s = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(0, 3)) : speed;
            applyStimulus(e, d, s, 1'($urandom_range(0, 2) == 0), 1);
        end

        applyStimulus(1, 0, 2'd1, 0, 13);
        RESET = 1'b1;
        resetModel();
        #1;
        checkOutput("hexA_async_reset", 64'(bus_a.HEX), 64'(42'h3FF_FFFF_FFFF));
        checkOutput("posA_async_reset", 64'(bus_a.POS), 64'(0));
        checkAll();
        en = 1'b0;
        @(posedge CLOCK_50);
        #1;
        checkAll();
        RESET = 1'b0;
        applyStimulus(0, 0, 2'd0, 0, 3);
        applyStimulus(1, 0, 2'd3, 0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
